mux_4_1: RTL and testbench
==========================

Name: mux_4_1

Overview:
4:1 multiplexer selecting one of four WIDTH-bit lanes packed on `in`, indexed by `sel`.
- Primary output `y` is purely combinational.
- A registered copy, a select-change pulse and per-lane saturating select counters run on the single clock for downstream timing and debug.
- Sits in datapath steering logic; the combinational path is usable without a clock.

Parameters:
WIDTH, 1, bit width of each input lane and of y/y_q
CNT_W, 8, width of each per-lane select counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in  input  4*WIDTH  packed lanes; lane k = in[k*WIDTH +: WIDTH]
sel  input  2  lane select, 0..3
en  input  1  capture enable for registered outputs
y  output  WIDTH  combinational selected lane
y_q  output  WIDTH  registered selected lane
sel_chg  output  1  one-cycle pulse, captured sel differs from previous captured sel
cnt0  output  CNT_W  capture count with sel=0
cnt1  output  CNT_W  capture count with sel=1
cnt2  output  CNT_W  capture count with sel=2
cnt3  output  CNT_W  capture count with sel=3

Behaviour:
- y = lane[sel], zero latency, no dependence on clk/rst/en.
  - With WIDTH=1: y = in[sel].
- X/Z on sel: y is don't-care in synthesis; no latch is inferred (full case, default = lane 0).
- Reset (rst=1 at posedge), all registered state cleared:
  - y_q=0, sel_chg=0, cnt0..cnt3=0.
  - Internal previous-sel register = 0; internal first-capture flag = 0.
- Capture cycle (posedge, rst=0, en=1):
  - y_q <= lane[sel], one-cycle latency relative to y.
  - cnt[sel] increments by 1 and saturates at 2^CNT_W-1; never wraps.
  - sel_chg <= 1 only if the first-capture flag is set and sel != previous sel; otherwise 0.
  - Previous sel <= sel; first-capture flag <= 1.
- en=0 at posedge: y_q, counters and previous sel hold; sel_chg <= 0.
- rst has priority over en. Reset mid-operation clears counters and the flag, so the first capture after reset never pulses sel_chg.
- Only one counter can change per cycle; no simultaneous-update hazards.

Optional Feature:
Macro MUX_PARITY_EN.
- Defined: adds output `par_q` (1 bit), registered alongside y_q under the same en/rst rules.
  - par_q <= ^lane[sel]; reset value 0.
- Undefined: `par_q` port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mux_pkg: localparam N_LANES=4, SEL_W=2, and typedef sel_t (logic [1:0]).
- One sub-module is natural: sat_counter (CNT_W, clk, rst, inc, count), instantiated four times with inc = en & (sel==k).
- Select logic is written inline.

Test Plan:
- WIDTH=1, in=4'b1000, sel=00,01,10,11 (combinational, no clock) -> y=0,0,0,1.
- in=4'b0101, sweep sel 0..3 -> y=1,0,1,0; with en=1, y_q follows one clock later.
- rst=1 for one clock after activity -> y_q=0, sel_chg=0, all cnt=0; next capture with sel=2 gives sel_chg=0 and cnt2=1.
- en=1, sel sequence 1,1,3 -> sel_chg=0,0,1; cnt1=2, cnt3=1.
- CNT_W=2, sel=0 held with en=1 for 5 clocks -> cnt0=3 (saturated); en=0 -> all outputs hold and sel_chg=0.
- MUX_PARITY_EN defined, WIDTH=4, lane2=4'b0111, sel=2, en=1 -> par_q=1 after one clock.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the mux_4_1 lane-select datapath.
package mux_pkg;
  localparam int unsigned N_LANES = 4;
  localparam int unsigned SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/sat_counter.sv
// Synchronous up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mux_4_1.sv
// 4:1 lane mux with combinational output plus registered copy, select-change pulse
// and per-lane saturating select counters. Optional par_q output under `MUX_PARITY_EN.
module mux_4_1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_LANES*WIDTH-1:0]   in,
  input  sel_t                       sel,
  input  logic                       en,
  output logic [WIDTH-1:0]           y,
  output logic [WIDTH-1:0]           y_q,
  output logic                       sel_chg,
  output logic [CNT_W-1:0]           cnt0,
  output logic [CNT_W-1:0]           cnt1,
  output logic [CNT_W-1:0]           cnt2,
  output logic [CNT_W-1:0]           cnt3
`ifdef MUX_PARITY_EN
  ,
  output logic                       par_q
`endif
);
  logic [WIDTH-1:0] lane_d;
  sel_t             prev_sel_q;
  logic             seen_q;
  logic             sel_chg_q;
  logic [CNT_W-1:0] cnt_q [N_LANES];

  // Full case with lane 0 as default keeps X/Z selects from inferring a latch.
  always_comb begin
    lane_d = in[0 +: WIDTH];
    case (sel)
      2'd0:    lane_d = in[0*WIDTH +: WIDTH];
      2'd1:    lane_d = in[1*WIDTH +: WIDTH];
      2'd2:    lane_d = in[2*WIDTH +: WIDTH];
      2'd3:    lane_d = in[3*WIDTH +: WIDTH];
      default: lane_d = in[0 +: WIDTH];
    endcase
  end

  assign y = lane_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q        <= '0;
      sel_chg_q  <= 1'b0;
      prev_sel_q <= '0;
      seen_q     <= 1'b0;
    end else if (en) begin
      y_q        <= lane_d;
      sel_chg_q  <= seen_q && (sel != prev_sel_q);
      prev_sel_q <= sel;
      seen_q     <= 1'b1;
    end else begin
      sel_chg_q  <= 1'b0;
    end
  end

  assign sel_chg = sel_chg_q;

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (en) begin
      par_q <= ^lane_d;
    end
  end
`endif

  for (genvar k = 0; k < N_LANES; k++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (en && (sel == sel_t'(k))),
      .count (cnt_q[k])
    );
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
endmodule

// File: tb/tb_mux_4_1.sv
// Directed self-checking bench for mux_4_1 (WIDTH=1, CNT_W=2 so saturation is reachable).
module tb_mux_4_1;
  localparam int unsigned WIDTH = 1;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [4*WIDTH-1:0] in;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             sel_chg;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`ifdef MUX_PARITY_EN
  logic             par_q;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mux_4_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .sel     (sel),
    .en      (en),
    .y       (y),
    .y_q     (y_q),
    .sel_chg (sel_chg),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3)
`ifdef MUX_PARITY_EN
    ,
    .par_q   (par_q)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag, input int unsigned c0, input int unsigned c1,
                            input int unsigned c2, input int unsigned c3);
    check({tag, "_cnt0"}, 32'(cnt0), c0);
    check({tag, "_cnt1"}, 32'(cnt1), c1);
    check({tag, "_cnt2"}, 32'(cnt2), c2);
    check({tag, "_cnt3"}, 32'(cnt3), c3);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in = '0; sel = 2'd0;

    // Combinational path before any clock edge
    in = 4'b1000;
    sel = 2'd0; #1; check("comb_1000_s0", 32'(y), 0);
    sel = 2'd1; #1; check("comb_1000_s1", 32'(y), 0);
    sel = 2'd2; #1; check("comb_1000_s2", 32'(y), 0);
    sel = 2'd3; #1; check("comb_1000_s3", 32'(y), 1);

    tick();
    rst = 1'b0;
    check("rst_yq", 32'(y_q), 0);
    check("rst_chg", 32'(sel_chg), 0);
    check_cnts("rst", 0, 0, 0, 0);

    // Sweep with capture: y immediate, y_q one clock later
    in = 4'b0101; en = 1'b1;
    sel = 2'd0; #1; check("sw_y0", 32'(y), 1);
    tick(); check("sw_yq0", 32'(y_q), 1); check("sw_chg0", 32'(sel_chg), 0);
    sel = 2'd1; #1; check("sw_y1", 32'(y), 0);
    tick(); check("sw_yq1", 32'(y_q), 0); check("sw_chg1", 32'(sel_chg), 1);
    sel = 2'd2; #1; check("sw_y2", 32'(y), 1);
    tick(); check("sw_yq2", 32'(y_q), 1); check("sw_chg2", 32'(sel_chg), 1);
    sel = 2'd3; #1; check("sw_y3", 32'(y), 0);
    tick(); check("sw_yq3", 32'(y_q), 0); check("sw_chg3", 32'(sel_chg), 1);
    check_cnts("sw", 1, 1, 1, 1);

    // Mid-operation reset, then first capture never pulses
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    check("rst2_yq", 32'(y_q), 0);
    check("rst2_chg", 32'(sel_chg), 0);
    check_cnts("rst2", 0, 0, 0, 0);
    en = 1'b1; sel = 2'd2;
    tick();
    check("first_chg", 32'(sel_chg), 0);
    check("first_yq", 32'(y_q), 1);
    check_cnts("first", 0, 0, 1, 0);

    // Sequence 1,1,3 after reset
    rst = 1'b1; tick(); rst = 1'b0;
    sel = 2'd1; tick(); check("seq_chg_a", 32'(sel_chg), 0);
    sel = 2'd1; tick(); check("seq_chg_b", 32'(sel_chg), 0);
    sel = 2'd3; tick(); check("seq_chg_c", 32'(sel_chg), 1);
    check_cnts("seq", 0, 2, 0, 1);
    en = 1'b0; sel = 2'd0; tick();
    check("seq_hold_chg", 32'(sel_chg), 0);
    check("seq_hold_yq", 32'(y_q), 0);
    check_cnts("seq_hold", 0, 2, 0, 1);

    // Saturation at 2^CNT_W-1 = 3
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; sel = 2'd0; in = 4'b0101;
    for (int i = 0; i < 5; i++) tick();
    check_cnts("sat", 3, 0, 0, 0);
    check("sat_yq", 32'(y_q), 1);
    check("sat_chg", 32'(sel_chg), 0);

    // en=0: everything holds, comb path still live
    en = 1'b0; in = 4'b0000; sel = 2'd3;
    tick(); tick();
    check("hold_yq", 32'(y_q), 1);
    check("hold_chg", 32'(sel_chg), 0);
    check("hold_y", 32'(y), 0);
    check_cnts("hold", 3, 0, 0, 0);

    // rst wins over en
    rst = 1'b1; en = 1'b1; in = 4'b1111; sel = 2'd1;
    tick();
    rst = 1'b0; en = 1'b0;
    check("prio_yq", 32'(y_q), 0);
    check("prio_chg", 32'(sel_chg), 0);
    check_cnts("prio", 0, 0, 0, 0);

`ifdef MUX_PARITY_EN
    check("par_rst", 32'(par_q), 0);
    in = 4'b0100; sel = 2'd2; en = 1'b1;
    tick();
    check("par_one", 32'(par_q), 1);
    in = 4'b1011; en = 1'b1;
    tick();
    check("par_zero", 32'(par_q), 0);
    en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
